numerical_derivative: RTL and testbench

- Streaming fixed-point differentiator; the inverse operation of the height calculator's trapezoidal integrator.
- Takes sampled signed signal words and produces the central-difference derivative (x[n] − x[n−2]) / (2T) per accepted sample.
- Sits in the same sample clock domain and feeds velocity/slope consumers downstream of the sensor sampler.
- Three-state priming FSM plus a 2-stage arithmetic pipeline, with valid handshake and saturation.

---
 rtl/numerical_derivative_pkg.sv | 26 ++
 rtl/numerical_derivative_sat_mul_shift.sv | 40 ++++
 rtl/numerical_derivative.sv | 96 +++++++++
 tb/tb_numerical_derivative.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/numerical_derivative_pkg.sv
// Shared constants, FSM encoding and scaling helper for the
// differentiator and the trapezoidal integrator.
package numerical_derivative_pkg;

  localparam int ND_N     = 64;
  localparam int ND_FRAC  = 9;
  localparam int ND_INV_W = 16;

  // Sample period in Q.FRAC; 512 is 1.0.
  localparam int unsigned ND_PERIOD_Q = 32'd512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HAVE1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  // 1/(2*period) in Q.FRAC, with period given in Q.FRAC.
  function automatic int unsigned inv_2t(
    input int unsigned period_q
  );
    return (32'd1 << (2 * ND_FRAC))
         / (32'd2 * period_q);
  endfunction

endpackage

// File: rtl/numerical_derivative_sat_mul_shift.sv
// Signed (N+1)-bit value times unsigned constant, floor shift by FRAC,
// saturate to N bits. Ports: i_d, i_k in; o_q result, o_sat clipped flag.
module sat_mul_shift #(
  parameter int N     = 64,
  parameter int FRAC  = 9,
  parameter int INV_W = 16
) (
  input  logic [N:0]       i_d,
  input  logic [INV_W-1:0] i_k,
  output logic [N-1:0]     o_q,
  output logic             o_sat
);

  localparam int PW = N + 1 + INV_W + 1;

  logic signed [PW-1:0] w_de;
  logic signed [PW-1:0] w_ke;
  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_q;
  logic [PW-N:0]        w_hi;

  assign w_de = {{(INV_W + 1){i_d[N]}}, i_d};
  assign w_ke = {{(N + 2){1'b0}}, i_k};
  // True product always fits PW bits.
  assign w_p  = w_de * w_ke;
  assign w_q  = w_p >>> FRAC;

  // Fits in N bits only if every bit from N-1 up is a sign copy.
  assign w_hi  = w_q[PW-1:N-1];
  assign o_sat = (w_hi != '0) && (w_hi != '1);

  always_comb begin
    o_q = w_q[N-1:0];
    if (o_sat) begin
      o_q = w_q[PW-1] ? {1'b1, {(N - 1){1'b0}}}
                      : {1'b0, {(N - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/numerical_derivative.sv
// Streaming central-difference differentiator: (x[n]-x[n-2])/(2T).
// Ports: clk, resetb, signal_input/sample_valid/start_differentiation in;
// derivative_result/derivative_valid/overflow out.
module numerical_derivative
  import numerical_derivative_pkg::*;
#(
  parameter int          N      = ND_N,
  parameter int          FRAC   = ND_FRAC,
  parameter int          INV_W  = ND_INV_W,
  parameter int unsigned INV_2T = inv_2t(ND_PERIOD_Q)
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic [N-1:0] signal_input,
  input  logic         sample_valid,
  input  logic         start_differentiation,
  output logic [N-1:0] derivative_result,
  output logic         derivative_valid,
  output logic         overflow
);

  localparam logic [INV_W-1:0] K = INV_W'(INV_2T);

  state_t       r_state;
  logic [N-1:0] r_x1;
  logic [N-1:0] r_x2;
  logic [N:0]   r_d1;
  logic         r_v1;

  logic         w_acc;
  logic [N-1:0] w_q;
  logic         w_sat;

  assign w_acc = sample_valid & start_differentiation;

  sat_mul_shift #(
    .N     (N),
    .FRAC  (FRAC),
    .INV_W (INV_W)
  ) u_sms (
    .i_d   (r_d1),
    .i_k   (K),
    .o_q   (w_q),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state           <= IDLE;
      r_x1              <= '0;
      r_x2              <= '0;
      r_d1              <= '0;
      r_v1              <= 1'b0;
      derivative_result <= '0;
      derivative_valid  <= 1'b0;
      overflow          <= 1'b0;
    end else if (!start_differentiation) begin
      // Flush: drop history and in-flight work, keep last result.
      r_state          <= IDLE;
      r_x1             <= '0;
      r_x2             <= '0;
      r_v1             <= 1'b0;
      derivative_valid <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      r_v1             <= 1'b0;
      derivative_valid <= r_v1;
      overflow         <= r_v1 & w_sat;
      if (r_v1) begin
        derivative_result <= w_q;
      end
      if (w_acc) begin
        unique case (r_state)
          IDLE: begin
            r_x1    <= signal_input;
            r_state <= HAVE1;
          end
          HAVE1: begin
            r_x2    <= r_x1;
            r_x1    <= signal_input;
            r_state <= RUN;
          end
          RUN: begin
            r_d1 <= {signal_input[N-1], signal_input}
                  - {r_x2[N-1], r_x2};
            r_v1 <= 1'b1;
            r_x2 <= r_x1;
            r_x1 <= signal_input;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_numerical_derivative.sv
// Directed bench: two instances (INV_2T=256 and 1024) on shared inputs,
// table-driven rows plus flush and async-reset sequences.
module tb_numerical_derivative;

  localparam logic [63:0] P62  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] M62  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  typedef struct {
    logic        sv;
    logic        en;
    logic [63:0] x;
    logic        va;
    logic [63:0] ra;
    logic        oa;
    logic        vb;
    logic [63:0] rb;
    logic        ob;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetb;
  logic [63:0] x;
  logic        sv;
  logic        en;
  logic [63:0] ra, rb;
  logic        va, vb, oa, ob;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  numerical_derivative #(.INV_2T(256)) dut_a (
    .clk                   (clk),
    .resetb                (resetb),
    .signal_input          (x),
    .sample_valid          (sv),
    .start_differentiation (en),
    .derivative_result     (ra),
    .derivative_valid      (va),
    .overflow              (oa)
  );

  numerical_derivative #(.INV_2T(1024)) dut_b (
    .clk                   (clk),
    .resetb                (resetb),
    .signal_input          (x),
    .sample_valid          (sv),
    .start_differentiation (en),
    .derivative_result     (rb),
    .derivative_valid      (vb),
    .overflow              (ob)
  );

  function automatic vec_t mk(
    input logic sv_i, input logic en_i, input logic [63:0] x_i,
    input logic va_i, input logic [63:0] ra_i, input logic oa_i,
    input logic vb_i, input logic [63:0] rb_i, input logic ob_i
  );
    vec_t v;
    v.sv = sv_i; v.en = en_i; v.x = x_i;
    v.va = va_i; v.ra = ra_i; v.oa = oa_i;
    v.vb = vb_i; v.rb = rb_i; v.ob = ob_i;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic e,
                     input logic [63:0] d);
    sv = s;
    en = e;
    x  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm,
                         input logic ev_a, input logic [63:0] er_a,
                         input logic eo_a,
                         input logic ev_b, input logic [63:0] er_b,
                         input logic eo_b);
    chk({nm, " va"}, 64'(va), 64'(ev_a));
    chk({nm, " ra"}, ra, er_a);
    chk({nm, " oa"}, 64'(oa), 64'(eo_a));
    chk({nm, " vb"}, 64'(vb), 64'(ev_b));
    chk({nm, " rb"}, rb, er_b);
    chk({nm, " ob"}, 64'(ob), 64'(eo_b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Ramp: diff 1024 -> 512 (a), 2048 (b)
    tbl.push_back(mk(1, 1, 0,    0, 0,   0, 0, 0,    0));
    tbl.push_back(mk(1, 1, 512,  0, 0,   0, 0, 0,    0));
    tbl.push_back(mk(1, 1, 1024, 0, 0,   0, 0, 0,    0));
    tbl.push_back(mk(1, 1, 1536, 1, 512, 0, 1, 2048, 0));
    tbl.push_back(mk(1, 1, 2048, 1, 512, 0, 1, 2048, 0));
    tbl.push_back(mk(0, 1, 0,    1, 512, 0, 1, 2048, 0));
    tbl.push_back(mk(0, 1, 0,    0, 512, 0, 0, 2048, 0));
    tbl.push_back(mk(1, 0, 999,  0, 512, 0, 0, 2048, 0));
    // Negative, floor rounding: -3 -> -2 (a), -6 (b)
    tbl.push_back(mk(1, 1, 0,   0, 512, 0, 0, 2048, 0));
    tbl.push_back(mk(1, 1, 0,   0, 512, 0, 0, 2048, 0));
    tbl.push_back(mk(1, 1, -64'sd3, 0, 512, 0, 0, 2048, 0));
    tbl.push_back(mk(0, 1, 0, 1, -64'sd2, 0, 1, -64'sd6, 0));
    tbl.push_back(mk(1, 0, 77, 0, -64'sd2, 0, 0, -64'sd6, 0));
    // Gapped: 100, 200, 300 -> 100 (a), 400 (b)
    tbl.push_back(mk(1, 1, 100, 0, -64'sd2, 0, 0, -64'sd6, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, -64'sd2, 0, 0, -64'sd6, 0));
    tbl.push_back(mk(1, 1, 200, 0, -64'sd2, 0, 0, -64'sd6, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, -64'sd2, 0, 0, -64'sd6, 0));
    tbl.push_back(mk(1, 1, 300, 0, -64'sd2, 0, 0, -64'sd6, 0));
    tbl.push_back(mk(0, 1, 0, 1, 100, 0, 1, 400, 0));
    tbl.push_back(mk(0, 1, 0, 0, 100, 0, 0, 400, 0));
    tbl.push_back(mk(1, 0, 5, 0, 100, 0, 0, 400, 0));
    // Positive saturation on b; a gives 2^62
    tbl.push_back(mk(1, 1, M62, 0, 100, 0, 0, 400, 0));
    tbl.push_back(mk(1, 1, 0,   0, 100, 0, 0, 400, 0));
    tbl.push_back(mk(1, 1, P62, 0, 100, 0, 0, 400, 0));
    tbl.push_back(mk(0, 1, 0, 1, P62, 0, 1, SMAX, 1));
    tbl.push_back(mk(0, 1, 0, 0, P62, 0, 0, SMAX, 0));
    tbl.push_back(mk(1, 0, 3, 0, P62, 0, 0, SMAX, 0));
    // Negative saturation on b; a gives -2^62
    tbl.push_back(mk(1, 1, P62, 0, P62, 0, 0, SMAX, 0));
    tbl.push_back(mk(1, 1, 0,   0, P62, 0, 0, SMAX, 0));
    tbl.push_back(mk(1, 1, M62, 0, P62, 0, 0, SMAX, 0));
    tbl.push_back(mk(0, 1, 0, 1, M62, 0, 1, SMIN, 1));
    tbl.push_back(mk(0, 1, 0, 0, M62, 0, 0, SMIN, 0));

    sv = 1'b0;
    en = 1'b0;
    x  = '0;
    resetb = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetb = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].sv, tbl[i].en, tbl[i].x);
      chk_all($sformatf("row%0d", i),
              tbl[i].va, tbl[i].ra, tbl[i].oa,
              tbl[i].vb, tbl[i].rb, tbl[i].ob);
    end

    // Flush with a result in flight
    cyc(1, 0, 777);
    cyc(1, 1, 0);
    cyc(1, 1, 512);
    cyc(1, 1, 1024);
    chk("fl pre va", 64'(va), 64'd0);
    cyc(1, 1, 1536);
    chk("fl run va", 64'(va), 64'd1);
    chk("fl run ra", ra, 64'd512);
    cyc(1, 0, 4096);
    chk("fl drop va", 64'(va), 64'd0);
    chk("fl drop vb", 64'(vb), 64'd0);
    chk("fl hold ra", ra, 64'd512);
    cyc(1, 1, 0);
    chk("fl n1 va", 64'(va), 64'd0);
    cyc(1, 1, 512);
    chk("fl n2 va", 64'(va), 64'd0);
    cyc(1, 1, 1024);
    chk("fl n3 va", 64'(va), 64'd0);
    cyc(0, 1, 0);
    chk("fl out va", 64'(va), 64'd1);
    chk("fl out ra", ra, 64'd512);
    chk("fl out rb", rb, 64'd2048);
    cyc(0, 1, 0);
    chk("fl end va", 64'(va), 64'd0);

    // Async reset while a strobe is high
    cyc(1, 1, 1536);
    cyc(1, 1, 2048);
    chk("ar pre va", 64'(va), 64'd1);
    #3;
    resetb = 1'b0;
    #1;
    chk_all("ar", 0, 0, 0, 0, 0, 0);
    #2;
    resetb = 1'b1;
    cyc(1, 1, 5000);
    chk("ar s1 va", 64'(va | vb), 64'd0);
    cyc(1, 1, 6000);
    chk("ar s2 va", 64'(va | vb), 64'd0);
    cyc(0, 1, 0);
    chk("ar s3 va", 64'(va | vb), 64'd0);
    cyc(0, 1, 0);
    chk("ar s4 va", 64'(va | vb), 64'd0);
    chk("ar s4 ra", ra, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
